// File: rtl/div_iter.sv
// rtl/div_iter.sv - radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}
// Optional DIV_EARLY_OUT_EN: short path when |dividend| < |divisor|.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [1:0] S_FREE    = 2'b00;
  localparam logic [1:0] S_DIVZERO = 2'b01;
  localparam logic [1:0] S_ON      = 2'b10;
  localparam logic [1:0] S_END     = 2'b11;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, divisor, op1_lat, q_fill;
  logic             q_sign, r_sign;

  logic             s1, s2, early_out;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx, dvd_nx, q_fix, r_fix;

  always_comb begin
    s1   = signed_div_i & opdata1_i[WIDTH-1];
    s2   = signed_div_i & opdata2_i[WIDTH-1];
    abs1 = s1 ? -opdata1_i : opdata1_i;
    abs2 = s2 ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    early_out = (abs1 < abs2);
`else
    early_out = 1'b0;
`endif
    // Shifted partial remainder needs WIDTH+1 bits; bit WIDTH of the difference is the borrow.
    trial  = {rem, dvd[WIDTH-1]} - {1'b0, divisor};
    borrow = trial[WIDTH];
    rem_nx = borrow ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
    dvd_nx = {dvd[WIDTH-2:0], ~borrow};
    q_fix  = q_sign ? -dvd_nx : dvd_nx;
    r_fix  = r_sign ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_FREE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            op1_lat <= opdata1_i;
            // Divide-by-zero and early-out share the one-cycle pass state; only the quotient fill differs.
            if (opdata2_i == '0) begin
              q_fill <= '1;
              state  <= S_DIVZERO;
            end else if (early_out) begin
              q_fill <= '0;
              state  <= S_DIVZERO;
            end else begin
              dvd     <= abs1;
              divisor <= abs2;
              rem     <= '0;
              cnt     <= '0;
              q_sign  <= s1 ^ s2;
              r_sign  <= s1;
              state   <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= {op1_lat, q_fill};
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state    <= S_END;
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
        end
        default: begin
          if (annul_i || !start_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - randomized self-checking bench for div_iter against an arithmetic model
module tb_div_iter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .signed_div_i(signed_div),
    .opdata1_i(opdata1), .opdata2_i(opdata2), .start_i(start),
    .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`endif
    return 33;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a division, scrambles operands after the start edge, waits for ready (bounded).
  task automatic run_div(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] held;
    signed_div = sg; opdata1 = a; opdata2 = b; start = 1'b1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      lat++;
      if (i == 0) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = $urandom_range(0, 1);
      end
      if (ready) break;
    end
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(model_lat(sg, a, b)));
    check({tag, "_res"}, result, model(sg, a, b));
    held = result;
    tick();
    check({tag, "_hold"}, {result[63:1] ^ held[63:1], ready}, 64'd1);
    start = 1'b0;
    tick();
    check({tag, "_drop"}, {63'd0, ready}, 64'd0);
    check({tag, "_clr"}, result, 64'd0);
  endtask

  // Starts 1000/3, then interrupts at cycle 10 either by annul or by reset.
  task automatic run_abort(input string tag, input bit use_reset);
    int seen;
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    start = 1'b0;
    if (use_reset) resetn = 1'b0; else annul = 1'b1;
    tick();
    resetn = 1'b1; annul = 1'b0;
    check({tag, "_out0"}, {result[62:0], ready}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready || result != 64'd0) seen++;
    end
    check({tag, "_noready"}, 64'(seen), 64'd0);
    run_div({tag, "_recover"}, 1'b0, 32'd1000, 32'd3);
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    bit sg;
    resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    tick(); tick();
    resetn = 1'b1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check("t1_const", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divzero", 1'b0, 32'h1234, 32'd0);
    run_div("divzero_s", 1'b1, 32'hFFFF_FF00, 32'd0);
    run_div("small_5_9", 1'b0, 32'd5, 32'd9);
    run_div("small_s", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FF9C);

    // annul together with start in FREE must not launch anything
    signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen++;
    end
    check("annul_free", 64'(seen), 64'd0);
    start = 1'b0; annul = 1'b0;
    tick();

    run_abort("annul", 1'b0);
    run_abort("reset", 1'b1);

    for (int k = 0; k < 30; k++) begin
      sg = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 20);
        1: b = $urandom;
        2: b = (k % 7 == 0) ? 32'd0 : -($urandom_range(1, 9));
        default: b = a + $urandom_range(0, 3);
      endcase
      run_div($sformatf("rand%0d", k), sg, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
